// File: rtl/led_scanner_pkg.sv
// Shared types and constants for the LED scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_scanner_pkg;

  typedef enum logic [1:0] {
    BOUNCE = 2'b00,
    ROT_L  = 2'b01,
    ROT_R  = 2'b10,
    FILL   = 2'b11
  } mode_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: raises step once every div+1 enabled cycles.
// Latency: step is combinational from the count register and en.
// Backpressure: en=0 freezes the count; clr restarts it and overrides a step.
module led_prescaler
  import led_scanner_pkg::*;
#(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 step
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt;

  // >= rather than == so that lowering div below the running count still steps
  assign step = en && (cnt >= div);

  // Count enabled cycles, returning to zero on a step or a restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// LED pattern generator: bounce / rotate-left / rotate-right / fill on a WIDTH-bit bank.
// Latency: led/dir/tick/wrap are registered and update on the edge where a step occurs.
// Backpressure: none; en=0 freezes prescaler and pattern, load restarts regardless of en.
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load,
  output logic [WIDTH-1:0]     led,
  output logic                 dir,
  output logic                 tick,
  output logic                 wrap
);

  localparam logic [WIDTH-1:0] LED_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             step;
  mode_t            mode_sel;
  logic             led_onehot;
  logic [WIDTH-1:0] led_nxt;
  logic             dir_nxt;
  logic             wrap_nxt;

  led_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .div  (div),
    .step (step)
  );

  assign mode_sel   = mode_t'(mode);
  assign led_onehot = (led != '0) && ((led & (led - LED_INIT)) == '0);

  // Next pattern value; the shifting modes restart from bit 0 if led is not one-hot
  always_comb begin
    led_nxt  = led;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    if (mode_sel != FILL && !led_onehot) begin
      led_nxt = LED_INIT;
      dir_nxt = DIR_LEFT;
    end else begin
      case (mode_sel)
        BOUNCE: begin
          if (dir == DIR_LEFT) begin
            if (led[WIDTH-1]) begin
              led_nxt = led >> 1;
              dir_nxt = DIR_RIGHT;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led[0]) begin
              led_nxt = led << 1;
              dir_nxt = DIR_LEFT;
            end else begin
              // landing on bit 0 closes one full bounce period
              led_nxt  = led >> 1;
              wrap_nxt = led[1];
            end
          end
        end
        ROT_L: begin
          led_nxt  = {led[WIDTH-2:0], led[WIDTH-1]};
          dir_nxt  = DIR_LEFT;
          wrap_nxt = led[WIDTH-1];
        end
        ROT_R: begin
          led_nxt  = {led[0], led[WIDTH-1:1]};
          dir_nxt  = DIR_RIGHT;
          wrap_nxt = led[0];
        end
        FILL: begin
          dir_nxt = DIR_LEFT;
          if (&led) begin
            led_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            led_nxt = {led[WIDTH-2:0], 1'b1};
          end
        end
        default: begin
          led_nxt = led;
        end
      endcase
    end
  end

  // Output registers: load beats step beats hold; pulses last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= LED_INIT;
      dir  <= DIR_LEFT;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      led  <= LED_INIT;
      dir  <= DIR_LEFT;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      led  <= led_nxt;
      dir  <= dir_nxt;
      tick <= 1'b1;
      wrap <= wrap_nxt;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// Self-checking bench for led_scanner: 4-bit and 8-bit instances share stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_led_scanner;
  import led_scanner_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       load  = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [7:0] div   = 8'd0;

  logic [3:0] led4;
  logic       dir4, tick4, wrap4;
  logic [7:0] led8;
  logic       dir8, tick8, wrap8;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_led4, m_led8, m_cnt;
  bit m_dir4, m_dir8, m_tick, m_wrap4, m_wrap8;

  typedef struct {
    int led;
    bit dir;
    bit wrap;
  } mres_t;

  typedef struct {
    logic [1:0] mode;
    bit         en;
    bit         load;
    logic [3:0] led;
    bit         dir;
    bit         tick;
    bit         wrap;
  } vec_t;

  vec_t vecs[$];

  led_scanner #(.WIDTH(4), .DIV_WIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div), .load(load),
    .led(led4), .dir(dir4), .tick(tick4), .wrap(wrap4)
  );

  led_scanner #(.WIDTH(8), .DIV_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div), .load(load),
    .led(led8), .dir(dir8), .tick(tick8), .wrap(wrap8)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pattern rules written on integer LED values
  function automatic mres_t model_step(input int w, input int led, input bit dir,
                                      input logic [1:0] md);
    mres_t r;
    int top  = 1 << (w - 1);
    int full = (1 << w) - 1;
    r.led = led; r.dir = dir; r.wrap = 0;
    if (md != 2'd3 && $countones(led) != 1) begin
      r.led = 1; r.dir = 1;
    end else begin
      case (md)
        2'd0: begin
          if (dir) begin
            if (led == top) begin r.led = led / 2; r.dir = 0; end
            else r.led = led * 2;
          end else begin
            if (led == 1) begin r.led = 2; r.dir = 1; end
            else begin r.led = led / 2; r.wrap = (r.led == 1); end
          end
        end
        2'd1: begin
          r.dir = 1;
          if (led == top) begin r.led = 1; r.wrap = 1; end
          else r.led = led * 2;
        end
        2'd2: begin
          r.dir = 0;
          if (led == 1) begin r.led = top; r.wrap = 1; end
          else r.led = led / 2;
        end
        default: begin
          r.dir = 1;
          if (led == full) begin r.led = 0; r.wrap = 1; end
          else r.led = (led * 2 + 1) & full;
        end
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_led4 = 1; m_led8 = 1; m_dir4 = 1; m_dir8 = 1;
    m_cnt = 0; m_tick = 0; m_wrap4 = 0; m_wrap8 = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    mres_t r;
    if (load) begin
      model_reset();
    end else if (en && m_cnt >= int'(div)) begin
      r = model_step(4, m_led4, m_dir4, mode);
      m_led4 = r.led; m_dir4 = r.dir; m_wrap4 = r.wrap;
      r = model_step(8, m_led8, m_dir8, mode);
      m_led8 = r.led; m_dir8 = r.dir; m_wrap8 = r.wrap;
      m_cnt = 0; m_tick = 1;
    end else begin
      if (en) m_cnt++;
      m_tick = 0; m_wrap4 = 0; m_wrap8 = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".led4"},  led4,  m_led4);
    check({tag, ".dir4"},  dir4,  m_dir4);
    check({tag, ".tick4"}, tick4, m_tick);
    check({tag, ".wrap4"}, wrap4, m_wrap4);
    check({tag, ".led8"},  led8,  m_led8);
    check({tag, ".dir8"},  dir8,  m_dir8);
    check({tag, ".tick8"}, tick8, m_tick);
    check({tag, ".wrap8"}, wrap8, m_wrap8);
  endtask

  task automatic step_cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  function automatic vec_t mk(input logic [1:0] m, input bit e, input bit l,
                              input logic [3:0] ld, input bit d, input bit t, input bit w);
    vec_t v;
    v.mode = m; v.en = e; v.load = l; v.led = ld; v.dir = d; v.tick = t; v.wrap = w;
    return v;
  endfunction

  initial begin
    int n;
    bit seen;
    logic [3:0] held;

    // expected WIDTH=4 outputs after each edge, div=0
    vecs.push_back(mk(2'd0, 1, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0100, 1, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b1000, 1, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0100, 0, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0010, 0, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(2'd0, 0, 0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(2'd0, 1, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0011, 1, 1, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0111, 1, 1, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b1111, 1, 1, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0000, 1, 1, 1));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0001, 1, 1, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0011, 1, 1, 0));
    vecs.push_back(mk(2'd3, 1, 0, 4'b0111, 1, 1, 0));
    vecs.push_back(mk(2'd1, 1, 0, 4'b0001, 1, 1, 0));
    vecs.push_back(mk(2'd1, 1, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(2'd1, 1, 0, 4'b0100, 1, 1, 0));
    vecs.push_back(mk(2'd1, 1, 0, 4'b1000, 1, 1, 0));
    vecs.push_back(mk(2'd1, 1, 0, 4'b0001, 1, 1, 1));
    vecs.push_back(mk(2'd2, 1, 0, 4'b1000, 0, 1, 1));
    vecs.push_back(mk(2'd2, 1, 0, 4'b0100, 0, 1, 0));
    vecs.push_back(mk(2'd2, 0, 0, 4'b0100, 0, 0, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0010, 0, 1, 0));
    vecs.push_back(mk(2'd0, 1, 0, 4'b0001, 0, 1, 1));

    // reset state
    #1 rst_n = 1'b0;
    #11;
    check("reset.led4", led4, 4'b0001);
    check("reset.dir4", dir4, 1'b1);
    check("reset.tick4", tick4, 1'b0);
    check("reset.wrap4", wrap4, 1'b0);
    check("reset.led8", led8, 8'h01);
    check("reset.dir8", dir8, 1'b1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // table vectors
    div = 8'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      en   = vecs[i].en;
      load = vecs[i].load;
      step_cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.led", i),  led4,  vecs[i].led);
      check($sformatf("vec%0d.dir", i),  dir4,  vecs[i].dir);
      check($sformatf("vec%0d.tick", i), tick4, vecs[i].tick);
      check($sformatf("vec%0d.wrap", i), wrap4, vecs[i].wrap);
    end
    load = 1'b0;

    // async reset between edges, mid-pattern
    mode = 2'd0; en = 1'b1;
    step_cycle("pre_rst");
    step_cycle("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    check("arst.led4", led4, 4'b0001);
    check("arst.dir4", dir4, 1'b1);
    check("arst.tick4", tick4, 1'b0);
    check("arst.wrap4", wrap4, 1'b0);
    check("arst.led8", led8, 8'h01);
    check("arst.dir8", dir8, 1'b1);
    model_reset();
    mode = 2'd2; div = 8'd3; en = 1'b1;
    #2;
    @(negedge clk) rst_n = 1'b1;

    // ROT_R, div=3, from reset: step every 4th cycle
    for (int c = 1; c <= 40; c++) begin
      step_cycle("rotr");
      check($sformatf("rotr.tick@%0d", c), tick8, (c % 4) == 0);
      if ((c % 4) == 0) begin
        check($sformatf("rotr.led@%0d", c), led8, 8'h80 >> (((c / 4) - 1) % 8));
        check($sformatf("rotr.wrap@%0d", c), wrap8, (((c / 4) - 1) % 8) == 0);
        check($sformatf("rotr.dir@%0d", c), dir8, 1'b0);
      end
    end

    // div=9 with en low for 5 cycles mid-count: step delayed by 5
    load = 1'b1; step_cycle("gap_load"); load = 1'b0;
    mode = 2'd0; div = 8'd9; en = 1'b1;
    for (int c = 0; c < 4; c++) step_cycle("gap_run");
    held = led4;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step_cycle("gap_off");
      check("gap_off.led_hold", led4, held);
      check("gap_off.tick", tick4, 1'b0);
    end
    en = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      step_cycle("gap_on");
      n++;
      if (tick4) seen = 1;
    end
    check("gap.cycles_to_step", n, 6);

    // load coinciding with a step in BOUNCE at 0100, dir=0
    load = 1'b1; div = 8'd2; step_cycle("col_load"); load = 1'b0;
    for (int c = 0; c < 12; c++) step_cycle("col_run");
    check("col.led_before", led4, 4'b0100);
    check("col.dir_before", dir4, 1'b0);
    step_cycle("col_wait");
    step_cycle("col_wait");
    load = 1'b1;
    step_cycle("col_hit");
    check("col.led", led4, 4'b0001);
    check("col.dir", dir4, 1'b1);
    check("col.tick", tick4, 1'b0);
    load = 1'b0;
    step_cycle("col_after");
    check("col.after1.tick", tick4, 1'b0);
    step_cycle("col_after");
    check("col.after2.tick", tick4, 1'b0);
    step_cycle("col_after");
    check("col.after3.tick", tick4, 1'b1);
    check("col.after3.led", led4, 4'b0010);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div = 8'($urandom_range(0, 4));
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 49) == 0);
      step_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
